// File: rtl/mux_striping_n.sv
// N-lane striping combiner: per-lane FIFOs merged into one ordered word stream
// by strict round-robin over enabled lanes, with a valid/ready output register.
module mux_striping_n #(
  parameter int DATA_W     = 32,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk_4f,
  input  logic                    reset,
  input  logic [LANES*DATA_W-1:0] data_in,
  input  logic [LANES-1:0]        valid_in,
  output logic [LANES-1:0]        lane_ready,
  input  logic [LANES-1:0]        lane_en,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       data_output,
  output logic                    valid_out,
  output logic [LANES-1:0]        overflow
);

  localparam int SEL_W = $clog2(LANES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem   [LANES][FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr  [LANES];
  logic [PTR_W-1:0]  r_rptr  [LANES];
  logic [CNT_W-1:0]  r_count [LANES];
  logic [LANES-1:0]  r_overflow;
  logic [SEL_W-1:0]  r_sel;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  logic              w_free;
  logic              w_head_ok;
  logic [LANES-1:0]  w_full;
  logic [LANES-1:0]  w_empty;
  logic [LANES-1:0]  w_push;
  logic [LANES-1:0]  w_pop;
  logic [SEL_W-1:0]  w_next_sel;

  assign w_free    = !r_valid || out_ready;
  assign w_head_ok = w_free && lane_en[r_sel] && !w_empty[r_sel];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_full[i]  = (r_count[i] == CNT_W'(FIFO_DEPTH));
      w_empty[i] = (r_count[i] == '0);
      w_pop[i]   = w_head_ok && (r_sel == SEL_W'(i));
      // A full lane still takes a word when its head leaves on the same edge.
      w_push[i]  = valid_in[i] && (!w_full[i] || w_pop[i]);
    end
  end

  // First enabled lane after r_sel, wrapping back to r_sel; holds if none enabled.
  always_comb begin
    logic [SEL_W-1:0] w_idx;
    logic             w_found;
    w_idx      = r_sel;
    w_found    = 1'b0;
    w_next_sel = r_sel;
    for (int k = 1; k <= LANES; k++) begin
      w_idx = r_sel + SEL_W'(k);
      if (!w_found && lane_en[w_idx]) begin
        w_next_sel = w_idx;
        w_found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_4f) begin
    for (int i = 0; i < LANES; i++) begin
      if (w_push[i]) r_mem[i][r_wptr[i]] <= data_in[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LANES; i++) begin
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_count[i] <= '0;
      end
      r_overflow <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + PTR_W'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PTR_W'(1);
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
          2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
          default: r_count[i] <= r_count[i];
        endcase
        if (valid_in[i] && !w_push[i]) r_overflow[i] <= 1'b1;
      end
    end
  end

  // Strict order: an enabled-but-empty selected lane stalls the whole stream.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      r_sel   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_free) begin
      if (lane_en[r_sel]) begin
        if (!w_empty[r_sel]) begin
          r_data  <= r_mem[r_sel][r_rptr[r_sel]];
          r_valid <= 1'b1;
          r_sel   <= w_next_sel;
        end else begin
          r_valid <= 1'b0;
        end
      end else begin
        r_valid <= 1'b0;
        r_sel   <= w_next_sel;
      end
    end
  end

  assign lane_ready  = ~w_full;
  assign overflow    = r_overflow;
  assign data_output = r_data;
  assign valid_out   = r_valid;

endmodule
